// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU pipeline definitions: load-op encoding
package cpu_defs;

  localparam int LOAD_OP_W = 3;

  localparam logic [LOAD_OP_W-1:0] LOP_NONE = 3'd0;
  localparam logic [LOAD_OP_W-1:0] LOP_LB   = 3'd1;
  localparam logic [LOAD_OP_W-1:0] LOP_LBU  = 3'd2;
  localparam logic [LOAD_OP_W-1:0] LOP_LH   = 3'd3;
  localparam logic [LOAD_OP_W-1:0] LOP_LHU  = 3'd4;
  localparam logic [LOAD_OP_W-1:0] LOP_LW   = 3'd5;
  localparam logic [LOAD_OP_W-1:0] LOP_LWL  = 3'd6;
  localparam logic [LOAD_OP_W-1:0] LOP_LWR  = 3'd7;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load data alignment and per-byte strobes, including LWL/LWR merge
module load_align #(
  parameter int LOAD_OP_W = cpu_defs::LOAD_OP_W
) (
  input  logic [LOAD_OP_W-1:0] load_op,
  input  logic [1:0]           a,
  input  logic [31:0]          rdata,
  input  logic [31:0]          result,
  output logic [31:0]          wdata,
  output logic [3:0]           wbytes
);
  import cpu_defs::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword; a[0] is irrelevant for halfwords
  // because misaligned halfword loads trap before reaching writeback.
  always_comb begin
    byte_sel = rdata[{a, 3'b000} +: 8];
    half_sel = a[1] ? rdata[31:16] : rdata[15:0];
  end

  // Per-op data placement and strobes; LWL/LWR only touch the bytes they merge.
  always_comb begin
    wdata  = result;
    wbytes = 4'b1111;
    case (load_op)
      LOAD_OP_W'(LOP_LB):  wdata = {{24{byte_sel[7]}}, byte_sel};
      LOAD_OP_W'(LOP_LBU): wdata = {24'd0, byte_sel};
      LOAD_OP_W'(LOP_LH):  wdata = {{16{half_sel[15]}}, half_sel};
      LOAD_OP_W'(LOP_LHU): wdata = {16'd0, half_sel};
      LOAD_OP_W'(LOP_LW):  wdata = rdata;
      LOAD_OP_W'(LOP_LWL): begin
        // 3-a is ~a for a 2-bit offset
        wdata  = rdata << {~a, 3'b000};
        wbytes = 4'b1111 << (~a);
      end
      LOAD_OP_W'(LOP_LWR): begin
        wdata  = rdata >> {a, 3'b000};
        wbytes = 4'b1111 >> a;
      end
      default: begin
        wdata  = result;
        wbytes = 4'b1111;
      end
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: handshake, load wait, register-file write port
module wb_stage #(
  parameter int LOAD_OP_W = cpu_defs::LOAD_OP_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ms_to_ws_valid,
  output logic                 ws_allowin,
  input  logic [31:0]          ms_pc,
  input  logic [4:0]           ms_dest,
  input  logic                 ms_gr_we,
  input  logic [LOAD_OP_W-1:0] ms_load_op,
  input  logic [31:0]          ms_result,
  input  logic                 data_data_ok,
  input  logic [31:0]          data_rdata,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [3:0]           rf_wbytes,
  output logic [31:0]          rf_wdata,
  output logic                 ws_fwd_valid,
  output logic [4:0]           ws_fwd_dest,
  output logic [31:0]          debug_wb_pc
);
  import cpu_defs::*;

  logic                 ws_valid;
  logic [31:0]          pc;
  logic [4:0]           dest;
  logic                 gr_we;
  logic [LOAD_OP_W-1:0] load_op;
  logic [31:0]          result;

  logic                 ws_ready_go;
  logic [31:0]          align_wdata;
  logic [3:0]           align_wbytes;

  // A load holds WB until its read data arrives; everything else retires at once.
  always_comb begin
    ws_ready_go = (load_op == LOAD_OP_W'(LOP_NONE)) || data_data_ok;
    ws_allowin  = !ws_valid || ws_ready_go;
  end

  // Valid bit: flush kills both the held instruction and any one arriving now.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid <= 1'b0;
    end else if (flush) begin
      ws_valid <= 1'b0;
    end else if (ws_allowin) begin
      ws_valid <= ms_to_ws_valid;
    end
  end

  // Payload captured on each accepted handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc      <= '0;
      dest    <= '0;
      gr_we   <= 1'b0;
      load_op <= '0;
      result  <= '0;
    end else if (ms_to_ws_valid && ws_allowin) begin
      pc      <= ms_pc;
      dest    <= ms_dest;
      gr_we   <= ms_gr_we;
      load_op <= ms_load_op;
      result  <= ms_result;
    end
  end

  load_align #(
    .LOAD_OP_W(LOAD_OP_W)
  ) u_load_align (
    .load_op(load_op),
    .a      (result[1:0]),
    .rdata  (data_rdata),
    .result (result),
    .wdata  (align_wdata),
    .wbytes (align_wbytes)
  );

  // Register-file port; strobes are zeroed so a killed write touches nothing.
  always_comb begin
    rf_we        = ws_valid && ws_ready_go && gr_we && !flush;
    rf_waddr     = dest;
    rf_wdata     = align_wdata;
    rf_wbytes    = rf_we ? align_wbytes : 4'b0000;
    ws_fwd_valid = ws_valid && gr_we;
    ws_fwd_dest  = dest;
    debug_wb_pc  = pc;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the five-stage in-order CPU pipeline, sitting between the memory stage and the register file. Accepts one instruction per cycle from the memory stage through a valid/allow-in handshake. For loads, waits for the data-SRAM read response and aligns it, including the unaligned LWL/LWR merge. Drives the register-file write port with per-byte write strobes (`rf_wbytes`), plus the debug trace and forwarding info.

## Interface
- `LOAD_OP_W`, default 3: width of the load-op code (values listed in Operation).
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ms_to_ws_valid`  in  1  memory stage presents an instruction.
- `ws_allowin`  out  1  writeback can accept this cycle.
- `ms_pc`  in  32  instruction PC.
- `ms_dest`  in  5  destination register number.
- `ms_gr_we`  in  1  instruction writes a GPR.
- `ms_load_op`  in  3  load kind.
- `ms_result`  in  32  ALU result: writeback value for non-loads, byte address for loads.
- `data_data_ok`  in  1  read data valid this cycle.
- `data_rdata`  in  32  raw aligned word from the data SRAM.
- `flush`  in  1  exception/eret flush: kill the instruction in WB.
- `rf_we`  out  1  register-file write enable.
- `rf_waddr`  out  5  write address.
- `rf_wbytes`  out  4  byte write strobes, bit i = byte i.
- `rf_wdata`  out  32  lane-placed write data.
- `ws_fwd_valid`  out  1  WB holds a valid GPR writer (for hazard/forward logic).
- `ws_fwd_dest`  out  5  its destination register.
- `debug_wb_pc`  out  32  PC of the retiring instruction.

## Operation
- State is `ws_valid` plus payload registers (`pc`, `dest`, `gr_we`, `load_op`, `result`).
- Payload loads on `ms_to_ws_valid && ws_allowin`.
- Handshake:
  - `ws_ready_go` = `load_op == NONE` or `data_data_ok`.
  - `ws_allowin` = `!ws_valid || ws_ready_go`.
  - `ws_valid` next value is `ms_to_ws_valid` whenever `ws_allowin`; otherwise it holds.
- Load ops:
  - NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, LWL=6, LWR=7.
  - `a` = `result[1:0]`.
- Data and strobes per op:
  - NONE: `wdata` = `result`, `wbytes` = 1111.
  - LB/LBU: byte `a` of `rdata`, sign/zero extended; 1111.
  - LH/LHU: halfword `a[1]`, sign/zero extended; 1111. `a[0]` is ignored; the address exception was already taken upstream.
  - LW: `rdata`; 1111.
  - LWL: `wdata` = `rdata << 8*(3-a)`; `wbytes` = a0:1000, a1:1100, a2:1110, a3:1111.
  - LWR: `wdata` = `rdata >> 8*a`; `wbytes` = a0:1111, a1:0111, a2:0011, a3:0001.
- Write port:
  - `rf_we` = `ws_valid && ws_ready_go && gr_we && !flush`.
  - `rf_wbytes` = the strobes above when `rf_we` is high, else 0000.
  - `rf_waddr` = `dest`.
- Forwarding: `ws_fwd_valid` = `ws_valid && gr_we`. It stays asserted while a load is stalled, so upstream interlocks.
- `debug_wb_pc` = `pc`.

## Timing
- Non-load: writes the register file in the cycle after acceptance, which is the cycle `ws_valid` is high. Throughput is 1 per cycle.
- Load: stalls (`ws_allowin` = 0) until `data_data_ok`. Writes and retires in the same cycle as `data_data_ok`. No read-data buffering is required. `data_data_ok` is only ever asserted while a load is held.
- `flush`:
  - Clears `ws_valid` at the next edge.
  - Suppresses `rf_we` in the same cycle.
  - A new instruction accepted in the flush cycle is also dropped.
- Reset:
  - `ws_valid` = 0 and all payload = 0.
  - Outputs: `rf_we` = 0, `rf_wbytes` = 0000, `ws_allowin` = 1, `ws_fwd_valid` = 0.
  - Reset during a stalled load discards it. A late `data_data_ok` after reset is ignored.
- `ms_dest` = 0 is written through unchanged; the register file discards it.

## Structure
- Shared package (`cpu_defs`): load-op encoding constants and `LOAD_OP_W`, which the decode and memory stages also use.
- One sub-module, `load_align`: purely combinational. Takes `load_op`, `a` and `rdata`; produces `wdata` and `wbytes`.

## Test plan
- ADDU result 0x1234_5678, dest 5, no stall → `rf_we` = 1, `waddr` 5, `wbytes` 1111, `wdata` 0x1234_5678 one cycle after acceptance; back-to-back issue sustains 1 per cycle.
- LB, a=2, `rdata` 0x0080_0000 → `wdata` 0xFFFF_FF80. LBU same → 0x0000_0080. LH, a=2, `rdata` 0x8001_0000 → 0xFFFF_8001.
- LWL, a=1, `rdata` 0xAABB_CCDD → `wbytes` 1100, `wdata` 0xCCDD_0000. LWR, a=1 → `wbytes` 0111, `wdata` 0x00AA_BBCC.
- LW with `data_data_ok` delayed 3 cycles → `ws_allowin` = 0 for 3 cycles, `ws_fwd_valid` = 1 throughout, single write on the ok cycle.
- `flush` while a load is stalled → no write, `ws_valid` = 0 next cycle. Reset mid-stall → all outputs at reset values, and a later `data_data_ok` causes no write.
